sup_counter_sched: RTL and testbench
====================================

Name: sup_counter_sched

Overview:
- Round-robin scheduler that shares one signed saturating-range up/down accumulator between N_REQ requesters.
- Each requester presents an opcode (load / add / subtract / nop) and a signed operand.
- The block arbitrates, executes one operation at a time with a ±LIMIT range guard, and returns a per-operation completion/reject status.
- Sits between software-visible command sources and the shared signed counter datapath; it owns the counter register.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, signed data width of operand and counter.
- LIMIT, 127, symmetric legal range; q is always kept within [-LIMIT, +LIMIT].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req  input  N_REQ  per-requester request; held high with op/opnd stable until its gnt.
- op  input  2*N_REQ  opcode per requester, slice i = op[2i+1:2i]; 00 nop, 01 up (q+opnd), 10 down (q-opnd), 11 load (q=opnd).
- opnd  input  WIDTH*N_REQ  signed operand per requester, slice i = opnd[WIDTH*i +: WIDTH].
- gnt  output  N_REQ  one-hot, one-cycle pulse: request accepted and op/opnd captured.
- busy  output  1  high whenever the FSM is not in IDLE.
- q  output  WIDTH  signed counter value (registered).
- done  output  1  one-cycle pulse at operation completion.
- done_id  output  $clog2(N_REQ)  index of the requester whose operation completed; valid with done.
- rej  output  1  with done: operation was rejected, q unchanged.
- rej_cnt  output  8  unsigned count of rejected operations; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous):
  - q=0, gnt=0, done=0, rej=0, done_id=0, rej_cnt=0, busy=0.
  - FSM goes to IDLE and the round-robin pointer is set so requester 0 has top priority.
  - An operation in flight is discarded with no done.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - With any req high, pick the winner: the first requester at or after ptr, cyclic.
  - On the clock edge, capture its op/opnd and id, pulse gnt[winner] for exactly that next cycle, and go to EXEC.
  - Set ptr = winner+1 mod N_REQ.
  - With no req high, stay in IDLE.
- EXEC:
  - Compute the candidate in WIDTH+2 bits: sign-extend q and opnd, then add, subtract, or pass opnd through (load).
  - If the candidate is > LIMIT or < -LIMIT: q holds and rej is set.
  - Otherwise q takes the candidate (truncated to WIDTH) and rej is cleared.
  - nop: q holds, rej=0.
  - Go to RESP.
- RESP:
  - done=1 for one cycle, with done_id and rej valid.
  - rej_cnt increments if rej=1 and rej_cnt<255.
  - Next state is IDLE.
- Latency: req seen in IDLE on cycle 0 → gnt high cycle 1 → q updated visible cycle 2 → done high cycle 2.
- Throughput: one operation per 3 cycles.
- Requests arriving while busy are ignored until IDLE; there is no queueing beyond the held req line.
- A requester that keeps req high after gnt issues a new operation.
  - Round-robin still lets every other pending requester win once before it wins again.
- Load of -LIMIT-1 (e.g. -128 at WIDTH=8) is rejected.
- The boundaries +LIMIT and -LIMIT themselves are legal.
- req dropping before gnt: the request is withdrawn, no side effects.
- req/op/opnd changes after gnt have no effect on the captured operation.

Test Plan:
- Reset then req[0]=1, op=11, opnd=100 → gnt[0] pulses 1 cycle after req, done 2 cycles after req with done_id=0, rej=0, q=100.
- From q=100, req[1] op=01 opnd=27 → q=127, rej=0; then req[1] op=01 opnd=1 → q stays 127, rej=1, rej_cnt=1.
- From q=0, op=10 opnd=-128 (q+128) → rej=1; op=11 opnd=-128 → rej=1; op=10 opnd=127 → q=-127, rej=0.
- All 4 req held high continuously with op=01 opnd=1 from q=0 → grants in order 0,1,2,3,0 with 3-cycle spacing; q=5 after the 5th done.
- Assert rst=0 during EXEC of a load 50 → q=0 immediately (asynchronous), no done pulse; after release, the next req[2] gets the grant with the pointer restored to requester 0 priority.
- 256 consecutive rejected operations → rej_cnt saturates at 255, q unchanged throughout.

Source files
------------

// File: rtl/sup_counter_sched.sv
// Round-robin scheduler sharing one signed, range-guarded up/down counter among N_REQ requesters.
// Each operation is granted in IDLE, executed in EXEC and reported in RESP; the companion checker guards invariants.
module sup_counter_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int LIMIT = 127,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] opnd,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic                   rej,
  output logic [7:0]             rej_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Range bounds carried in the two-bit-wider candidate domain so overflow never wraps.
  localparam logic signed [WIDTH+1:0] LIM_P = (WIDTH+2)'(LIMIT);
  localparam logic signed [WIDTH+1:0] LIM_N = -LIM_P;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic             rej_q, rej_d;
  logic [7:0]       rej_cnt_q, rej_cnt_d;

  logic                    win_found_s;
  logic [IDW-1:0]          win_id_s;
  logic [IDW-1:0]          cand_id_s;
  logic [1:0]              win_op_s;
  logic [WIDTH-1:0]        win_opnd_s;
  logic [IDW-1:0]          ptr_next_s;
  logic signed [WIDTH+1:0] q_ext_s;
  logic signed [WIDTH+1:0] d_ext_s;
  logic signed [WIDTH+1:0] cand_s;
  logic                    in_range_s;

  // Cyclic search for the first pending requester at or after the pointer.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_id_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_id_s = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!win_found_s && req[cand_id_s]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_id_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pick the winner's opcode/operand slices and the pointer value that follows it.
  always_comb begin
    win_op_s   = OP_NOP;
    win_opnd_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == win_id_s) begin
        win_op_s   = op[2*k +: 2];
        win_opnd_s = opnd[WIDTH*k +: WIDTH];
      end else begin
        win_op_s   = win_op_s;
      end
    end
    if (win_id_s == IDW'(N_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_id_s + IDW'(1);
    end
  end

  // Candidate result in WIDTH+2 bits, then the symmetric range check.
  always_comb begin
    q_ext_s = {{2{cnt_q[WIDTH-1]}}, cnt_q};
    d_ext_s = {{2{opnd_q[WIDTH-1]}}, opnd_q};
    case (op_q)
      OP_UP:   cand_s = q_ext_s + d_ext_s;
      OP_DOWN: cand_s = q_ext_s - d_ext_s;
      OP_LOAD: cand_s = d_ext_s;
      default: cand_s = q_ext_s;
    endcase
    in_range_s = (cand_s <= LIM_P) && (cand_s >= LIM_N);
  end

  // Scheduler FSM next-state and output-register next values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    gnt_d     = '0;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    rej_d     = rej_q;
    rej_cnt_d = rej_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d = S_EXEC;
          gnt_d   = N_REQ'(1) << win_id_s;
          id_d    = win_id_s;
          op_d    = win_op_s;
          opnd_d  = win_opnd_s;
          ptr_d   = ptr_next_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (op_q == OP_NOP) begin
          rej_d = 1'b0;
        end else if (in_range_s) begin
          cnt_d = cand_s[WIDTH-1:0];
          rej_d = 1'b0;
        end else begin
          rej_d = 1'b1;
        end
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (rej_q && (rej_cnt_q != 8'hFF)) begin
          rej_cnt_d = rej_cnt_q + 8'd1;
        end else begin
          rej_cnt_d = rej_cnt_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      op_q      <= OP_NOP;
      opnd_q    <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      rej_q     <= 1'b0;
      rej_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      rej_q     <= rej_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign q       = cnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign rej     = rej_q;
  assign rej_cnt = rej_cnt_q;

  sup_counter_sched_chk #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .LIMIT (LIMIT)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .gnt  (gnt_q),
    .busy (busy),
    .done (done_q),
    .q    (cnt_q)
  );

endmodule

// Invariant checker: grant is at most one-hot, done never overlaps a grant, counter stays in range.
module sup_counter_sched_chk #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int LIMIT = 127
) (
  input logic             clk,
  input logic             rst,
  input logic [N_REQ-1:0] gnt,
  input logic             busy,
  input logic             done,
  input logic [WIDTH-1:0] q
);

  localparam logic signed [WIDTH+1:0] LIM_P = (WIDTH+2)'(LIMIT);
  localparam logic signed [WIDTH+1:0] LIM_N = -LIM_P;

  logic signed [WIDTH+1:0] q_ext_s;

  assign q_ext_s = {{2{q[WIDTH-1]}}, q};

  // Sampled every active edge outside reset.
  always @(posedge clk) begin
    if (rst) begin
      a_gnt_onehot: assert ($onehot0(gnt));
      a_done_no_gnt: assert (!(done && (gnt != '0)));
      a_done_busy: assert (!done || busy);
      a_q_range: assert ((q_ext_s <= LIM_P) && (q_ext_s >= LIM_N));
    end
  end

endmodule

// File: tb/tb_sup_counter_sched.sv
// Directed bench for sup_counter_sched: hand-computed expectations for grants, results, rejects and reset.
module tb_sup_counter_sched;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] opnd;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  q;
  logic        done;
  logic [1:0]  done_id;
  logic        rej;
  logic [7:0]  rej_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sup_counter_sched #(.N_REQ(4), .WIDTH(8), .LIMIT(127)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .opnd    (opnd),
    .gnt     (gnt),
    .busy    (busy),
    .q       (q),
    .done    (done),
    .done_id (done_id),
    .rej     (rej),
    .rej_cnt (rej_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] id, input logic [1:0] o, input logic [7:0] d);
    req  = req | (4'b0001 << id);
    op   = (op & ~(8'b11 << (2 * id))) | (8'(o) << (2 * id));
    opnd = (opnd & ~(32'hFF << (8 * id))) | (32'(d) << (8 * id));
  endtask

  task automatic run_op(input logic [1:0] id, input logic [1:0] o, input logic [7:0] d,
                        input logic [7:0] exp_q, input logic exp_rej, input logic [7:0] exp_cnt);
    put(id, o, d);
    chk("gnt_before", 8'(gnt), 8'd0);
    tick();
    chk("gnt", 8'(gnt), 8'(4'b0001 << id));
    chk("busy_exec", 8'(busy), 8'd1);
    req = 4'b0000;
    tick();
    chk("done", 8'(done), 8'd1);
    chk("done_id", 8'(done_id), 8'(id));
    chk("rej", 8'(rej), 8'(exp_rej));
    chk("q", q, exp_q);
    tick();
    chk("done_drop", 8'(done), 8'd0);
    chk("busy_idle", 8'(busy), 8'd0);
    chk("rej_cnt", rej_cnt, exp_cnt);
  endtask

  initial begin
    rst  = 1'b0;
    req  = 4'b0000;
    op   = 8'd0;
    opnd = 32'd0;
    tick();
    tick();
    chk("rst_q", q, 8'd0);
    chk("rst_gnt", 8'(gnt), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_rej", 8'(rej), 8'd0);
    chk("rst_done_id", 8'(done_id), 8'd0);
    chk("rst_rej_cnt", rej_cnt, 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    rst = 1'b1;
    tick();

    // Load, climb to the upper bound, then overshoot it.
    run_op(2'd0, LOAD, 8'd100, 8'd100, 1'b0, 8'd0);
    run_op(2'd1, UP,   8'd27,  8'd127, 1'b0, 8'd0);
    run_op(2'd1, UP,   8'd1,   8'd127, 1'b1, 8'd1);

    // Lower-bound cases from zero.
    run_op(2'd2, LOAD, 8'd0,   8'd0,        1'b0, 8'd1);
    run_op(2'd2, DOWN, 8'h80,  8'd0,        1'b1, 8'd2);
    run_op(2'd2, LOAD, 8'h80,  8'd0,        1'b1, 8'd3);
    run_op(2'd2, DOWN, 8'd127, 8'(-127),    1'b0, 8'd3);
    run_op(2'd2, DOWN, 8'd1,   8'(-127),    1'b1, 8'd4);
    run_op(2'd3, LOAD, 8'd0,   8'd0,        1'b0, 8'd4);

    // All four requesters held high: strict rotation, one grant every three cycles.
    put(2'd0, UP, 8'd1);
    put(2'd1, UP, 8'd1);
    put(2'd2, UP, 8'd1);
    put(2'd3, UP, 8'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", 8'(gnt), 8'(4'b0001 << (k % 4)));
      tick();
      chk("rr_done", 8'(done), 8'd1);
      chk("rr_done_id", 8'(done_id), 8'(k % 4));
      chk("rr_q", q, 8'(k + 1));
      tick();
      chk("rr_gap", 8'(gnt), 8'd0);
    end
    req = 4'b0000;
    chk("rr_final_q", q, 8'd5);

    // Asynchronous reset during EXEC of a load.
    put(2'd2, LOAD, 8'd50);
    tick();
    chk("ar_gnt", 8'(gnt), 8'b0100);
    req = 4'b0000;
    rst = 1'b0;
    #1;
    chk("ar_q", q, 8'd0);
    chk("ar_busy", 8'(busy), 8'd0);
    chk("ar_gnt_clr", 8'(gnt), 8'd0);
    chk("ar_done", 8'(done), 8'd0);
    chk("ar_rej_cnt", rej_cnt, 8'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_no_done1", 8'(done), 8'd0);
    tick();
    chk("ar_no_done2", 8'(done), 8'd0);
    chk("ar_q_hold", q, 8'd0);

    // Pointer back at requester 0: 0 beats 3 even though the last grant was 2.
    put(2'd0, LOAD, 8'd10);
    put(2'd3, LOAD, 8'd20);
    tick();
    chk("ptr_gnt", 8'(gnt), 8'b0001);
    req = 4'b0000;
    tick();
    chk("ptr_done_id", 8'(done_id), 8'd0);
    chk("ptr_q", q, 8'd10);
    tick();
    run_op(2'd2, LOAD, 8'(-5), 8'(-5), 1'b0, 8'd0);

    // Reject counter saturation with q untouched.
    for (int i = 1; i <= 256; i++) begin
      run_op(2'd1, LOAD, 8'h80, 8'(-5), 1'b1, (i > 255) ? 8'd255 : 8'(i));
    end
    chk("sat_cnt", rej_cnt, 8'd255);
    run_op(2'd0, NOP, 8'd33, 8'(-5), 1'b0, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
